// File: rtl/signal_demod.sv
// BPSK/QPSK-style integrate-and-dump demodulator: 8 samples per symbol per rail,
// sign decision, 4 symbols packed MSB-first into a byte written to RAM.
module signal_demod #(
    parameter logic [15:0] MSG_BYTES = 16'd530
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [12:0] INPUT_I,
    input  logic signed [12:0] INPUT_Q,
    input  logic               in_valid,
    output logic [9:0]         ram_addr,
    output logic [7:0]         ram_wdata,
    output logic               write_enable,
    output logic [1:0]         sym_out,
    output logic               sym_valid,
    output logic               done,
    output logic [1:0]         dbg_state_o
);
    localparam int SPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] acc_i_q, acc_q_q;
    logic [2:0]  sample_cnt_q;
    logic [1:0]  sym_cnt_q;
    logic [15:0] byte_cnt_q;
    logic [9:0]  addr_q;
    logic [7:0]  byte_q;
    logic [9:0]  ram_addr_q;
    logic [7:0]  ram_wdata_q;
    logic        write_enable_q;
    logic [1:0]  sym_out_q;
    logic        sym_valid_q;
    logic        done_q;

    logic [15:0] sum_i_d, sum_q_d;
    logic [1:0]  sym_d;
    logic [7:0]  byte_d;

    // Accumulator plus the current sample; on the last sample of a symbol its
    // sign is the decision, otherwise it becomes the new accumulator value.
    always_comb begin
        sum_i_d = acc_i_q + {{3{INPUT_I[12]}}, INPUT_I};
        sum_q_d = acc_q_q + {{3{INPUT_Q[12]}}, INPUT_Q};
        sym_d   = {sum_i_d[15], sum_q_d[15]};
        byte_d  = {byte_q[5:0], sym_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            acc_i_q        <= '0;
            acc_q_q        <= '0;
            sample_cnt_q   <= '0;
            sym_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            addr_q         <= '0;
            byte_q         <= '0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            write_enable_q <= 1'b0;
            sym_out_q      <= '0;
            sym_valid_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            sym_valid_q    <= 1'b0;
            write_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q      <= RUN;
                        acc_i_q      <= '0;
                        acc_q_q      <= '0;
                        sample_cnt_q <= '0;
                        sym_cnt_q    <= '0;
                        byte_cnt_q   <= '0;
                        addr_q       <= '0;
                        byte_q       <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (sample_cnt_q == 3'(SPS - 1)) begin
                            acc_i_q      <= '0;
                            acc_q_q      <= '0;
                            sample_cnt_q <= '0;
                            sym_out_q    <= sym_d;
                            sym_valid_q  <= 1'b1;
                            byte_q       <= byte_d;
                            sym_cnt_q    <= sym_cnt_q + 2'd1;
                            if (sym_cnt_q == 2'd3) begin
                                write_enable_q <= 1'b1;
                                ram_wdata_q    <= byte_d;
                                ram_addr_q     <= addr_q;
                                addr_q         <= addr_q + 10'd1;
                                byte_cnt_q     <= byte_cnt_q + 16'd1;
                                // Final byte: done rises together with its write strobe.
                                if (byte_cnt_q == MSG_BYTES - 16'd1) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end
                            end
                        end else begin
                            acc_i_q      <= sum_i_d;
                            acc_q_q      <= sum_q_d;
                            sample_cnt_q <= sample_cnt_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (enable) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign write_enable = write_enable_q;
    assign sym_out      = sym_out_q;
    assign sym_valid    = sym_valid_q;
    assign done         = done_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_signal_demod.sv
// Bench for signal_demod: one-byte and three-byte instances share the sample
// bus; a sign-of-sum model feeds expected symbol/byte queues checked on negedge.
module tb_signal_demod;
    localparam int SPS = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               en1, en3;
    logic signed [12:0] in_i, in_q;
    logic               in_valid;

    logic [9:0] ram_addr1, ram_addr3;
    logic [7:0] ram_wdata1, ram_wdata3;
    logic       we1, we3;
    logic [1:0] sym_out1, sym_out3;
    logic       sym_valid1, sym_valid3;
    logic       done1, done3;
    logic [1:0] st1, st3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp1_q[$];
    logic [17:0] exp3_q[$];
    logic [1:0]  sym1_q[$];
    logic [1:0]  sym3_q[$];

    int wr1_cnt = 0;
    int wr3_cnt = 0;
    int cyc = 0;
    int last_wr3 = 0;

    logic [7:0] mbyte;
    int         mcnt;
    logic [9:0] maddr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signal_demod #(.MSG_BYTES(16'd1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .INPUT_I(in_i), .INPUT_Q(in_q),
        .in_valid(in_valid), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .write_enable(we1), .sym_out(sym_out1), .sym_valid(sym_valid1),
        .done(done1), .dbg_state_o(st1)
    );

    signal_demod #(.MSG_BYTES(16'd3)) dut3 (
        .clk(clk), .reset(reset), .enable(en3), .INPUT_I(in_i), .INPUT_Q(in_q),
        .in_valid(in_valid), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .write_enable(we3), .sym_out(sym_out3), .sym_valid(sym_valid3),
        .done(done3), .dbg_state_o(st3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (sym_valid1) begin
                if (sym1_q.size() == 0) check("sym1_unexpected", 32'(sym_valid1), 32'd0);
                else check("sym1", 32'(sym_out1), 32'(sym1_q.pop_front()));
            end
            if (sym_valid3) begin
                if (sym3_q.size() == 0) check("sym3_unexpected", 32'(sym_valid3), 32'd0);
                else check("sym3", 32'(sym_out3), 32'(sym3_q.pop_front()));
            end
            if (we1) begin
                if (exp1_q.size() == 0) check("wr1_unexpected", 32'(we1), 32'd0);
                else check("wr1", 32'({ram_addr1, ram_wdata1}), 32'(exp1_q.pop_front()));
                check("wr1_done", 32'(done1), 32'd1);
                wr1_cnt++;
            end
            if (we3) begin
                if (exp3_q.size() == 0) check("wr3_unexpected", 32'(we3), 32'd0);
                else check("wr3", 32'({ram_addr3, ram_wdata3}), 32'(exp3_q.pop_front()));
                check("wr3_done", 32'(done3), (wr3_cnt % 3 == 2) ? 32'd1 : 32'd0);
                if (wr3_cnt % 3 != 0) check("wr3_gap", 32'(cyc - last_wr3), 32'd32);
                last_wr3 = cyc;
                wr3_cnt++;
            end
        end
    end

    task automatic drive_sample(input int iv, input int qv, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_i = 13'($urandom);
            in_q = 13'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_i = 13'(iv);
        in_q = 13'(qv);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic start_frame(input int sel);
        if (sel == 1) en1 = 1'b1; else en3 = 1'b1;
        @(posedge clk); #1;
        en1 = 1'b0;
        en3 = 1'b0;
        mbyte = '0;
        mcnt  = 0;
        maddr = '0;
    endtask

    task automatic send_sym(input int sel, input int iv, input int qv, input bit rnd,
                            input int max_gap);
        int si, sq;
        int sum_i = 0;
        int sum_q = 0;
        logic [1:0] s;
        for (int k = 0; k < SPS; k++) begin
            si = rnd ? int'($urandom_range(8191, 0)) - 4096 : iv;
            sq = rnd ? int'($urandom_range(8191, 0)) - 4096 : qv;
            sum_i += si;
            sum_q += sq;
            drive_sample(si, sq, max_gap);
        end
        s = {sum_i < 0, sum_q < 0};
        if (sel == 1) sym1_q.push_back(s); else sym3_q.push_back(s);
        mbyte = {mbyte[5:0], s};
        mcnt++;
        if (mcnt == 4) begin
            if (sel == 1) exp1_q.push_back({maddr, mbyte}); else exp3_q.push_back({maddr, mbyte});
            maddr = maddr + 10'd1;
            mcnt = 0;
        end
    endtask

    task automatic wait_done_ack(input int sel);
        int n = 0;
        while (((sel == 1) ? done1 : done3) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_rise", 32'((sel == 1) ? done1 : done3), 32'd1);
        // Samples arriving in DONE must be ignored
        repeat (4) drive_sample(-300, -300, 0);
        check("done_hold", 32'((sel == 1) ? done1 : done3), 32'd1);
        if (sel == 1) en1 = 1'b1; else en3 = 1'b1;
        @(posedge clk); #1;
        en1 = 1'b0;
        en3 = 1'b0;
        check("done_fall", 32'((sel == 1) ? done1 : done3), 32'd0);
        check("idle_after_ack", 32'((sel == 1) ? st1 : st3), 32'd0);
    endtask

    task automatic frame_033(input int max_gap);
        int w0;
        w0 = wr1_cnt;
        start_frame(1);
        send_sym(1, 100, 100, 1'b0, max_gap);
        send_sym(1, -100, 100, 1'b0, max_gap);
        send_sym(1, 100, -100, 1'b0, max_gap);
        send_sym(1, -1, -1, 1'b0, max_gap);
        wait_done_ack(1);
        check("f033_writes", 32'(wr1_cnt - w0), 32'd1);
        check("f033_q_empty", 32'(exp1_q.size() + sym1_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        int vals[3];
        reset = 1'b1;
        repeat (2) begin
            en1 = 1'($urandom); en3 = 1'($urandom);
            in_valid = 1'($urandom);
            in_i = 13'($urandom); in_q = 13'($urandom);
            @(posedge clk); #1;
        end
        check("rst_we1", 32'(we1), 32'd0);
        check("rst_we3", 32'(we3), 32'd0);
        reset = 1'b0;
        en1 = 1'b0; en3 = 1'b0; in_valid = 1'b0;
        in_i = '0; in_q = '0;
        check("rst_addr1", 32'(ram_addr1), 32'd0);
        check("rst_wdata1", 32'(ram_wdata1), 32'd0);
        check("rst_sym1", 32'({sym_out1, sym_valid1}), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_state1", 32'(st1), 32'd0);
        check("rst_out3", 32'({ram_addr3, ram_wdata3, sym_out3, sym_valid3, done3}), 32'd0);

        // Known four-symbol byte 0x27, then the same with random gaps
        frame_033(0);
        frame_033(3);

        // Boundary sample values
        vals[0] = 0; vals[1] = -4096; vals[2] = 4095;
        foreach (vals[v]) begin
            w0 = wr1_cnt;
            start_frame(1);
            repeat (4) send_sym(1, vals[v], vals[v], 1'b0, 0);
            wait_done_ack(1);
            check("bound_writes", 32'(wr1_cnt - w0), 32'd1);
        end

        // Three-byte frames of random samples, back to back, twice
        for (int f = 0; f < 2; f++) begin
            start_frame(3);
            repeat (12) send_sym(3, 0, 0, 1'b1, 0);
            wait_done_ack(3);
            check("f3_writes", 32'(wr3_cnt), 32'(3 * (f + 1)));
            check("f3_q_empty", 32'(exp3_q.size() + sym3_q.size()), 32'd0);
        end

        // Reset in the middle of a frame discards the partial byte
        w0 = wr1_cnt;
        start_frame(1);
        send_sym(1, 100, 100, 1'b0, 0);
        drive_sample(-50, 70, 0);
        drive_sample(-50, 70, 0);
        reset = 1'b1;
        repeat (2) begin
            check("midrst_we", 32'(we1), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        exp1_q.delete();
        repeat (3) begin
            check("midrst_we_after", 32'(we1), 32'd0);
            @(posedge clk); #1;
        end
        check("midrst_state", 32'(st1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        check("midrst_writes", 32'(wr1_cnt - w0), 32'd0);
        check("midrst_sym_q", 32'(sym1_q.size()), 32'd0);
        frame_033(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/signal_demod.md
SIGNAL_DEMOD -- requirements
Module: signal_demod

Interface
REQ-001 Parameter: MSG_BYTES, default 16'd530, number of bytes recovered and written per frame; legal range 1..1024.
REQ-002 Parameter: SPS, fixed at 8, samples per symbol; not overridable.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 enable  input  1  starts a frame in IDLE; acknowledges completion in DONE.
REQ-006 INPUT_I  input  13  signed two's-complement in-phase sample.
REQ-007 INPUT_Q  input  13  signed two's-complement quadrature sample.
REQ-008 in_valid  input  1  INPUT_I/INPUT_Q carry a sample this cycle.
REQ-009 ram_addr  output  10  byte write address.
REQ-010 ram_wdata  output  8  recovered byte.
REQ-011 write_enable  output  1  one-cycle write strobe qualifying ram_addr/ram_wdata.
REQ-012 sym_out  output  2  last decided symbol {bit_I, bit_Q}, for monitoring.
REQ-013 sym_valid  output  1  one-cycle pulse when sym_out updates.
REQ-014 done  output  1  high while in DONE.

Function
REQ-015 States: IDLE, RUN, DONE; all outputs are registered.
REQ-016 IDLE: enable=1 -> RUN; on that edge clear both accumulators, sample_cnt (3b), sym_cnt (2b), byte_cnt (16b), addr (10b) and the byte shift register.
REQ-017 RUN: each in_valid=1 cycle adds the sign-extended INPUT_I/INPUT_Q to 16-bit signed accumulators acc_I/acc_Q and increments sample_cnt; in_valid=0 cycles hold all state (gaps are allowed).
REQ-018 Worst-case accumulator range is -32768..+32760; no saturation logic; accumulators never overflow.
REQ-019 When in_valid=1 and sample_cnt=7: form sum = acc + current sample per rail; bit = sign bit of sum (1 if negative, 0 if >= 0); reload accumulators with 0; sample_cnt wraps to 0.
REQ-020 Symbol decision: sym_out <= {bit_I, bit_Q} and sym_valid pulses on the following cycle; the byte shifts left by 2 with {bit_I, bit_Q} entering the LSBs; sym_cnt increments.
REQ-021 Byte order: the first symbol of a byte occupies bits [7:6] and the fourth occupies bits [1:0].
REQ-022 On the decision with sym_cnt=3: next cycle write_enable=1, ram_wdata=completed byte, ram_addr=addr; addr and byte_cnt then increment.
REQ-023 The byte write overlaps continued sample acceptance; RUN never stalls, and in_valid may be high every cycle.
REQ-024 If the completed byte is number MSG_BYTES (byte_cnt = MSG_BYTES-1), the state goes to DONE on the same edge the write is registered; write_enable and done rise together.
REQ-025 DONE: done=1; in_valid is ignored; enable=1 -> IDLE, and done falls the next cycle.
REQ-026 enable is ignored in RUN; in_valid is ignored in IDLE and DONE.
REQ-027 write_enable and sym_valid are low in every cycle not named in REQ-020/REQ-022.
REQ-028 addr does not wrap within a frame (MSG_BYTES <= 1024); ram_addr holds its last value between writes.

Reset
REQ-029 reset=1 forces IDLE and clears ram_addr, ram_wdata, write_enable, sym_out, sym_valid, done, both accumulators and all counters to 0.
REQ-030 reset takes priority over every other input, including mid-frame; a partial byte is discarded and not written.
REQ-031 The first frame after reset writes starting at address 0.

Verification
REQ-032 Reset: assert for 2 cycles with random inputs -> all outputs 0, no write_enable, done=0.
REQ-033 MSG_BYTES=1, four 8-sample symbols: (I=+100,Q=+100), (-100,+100), (+100,-100), (-1,-1) -> sym_out 00,10,01,11; single write ram_addr=0, ram_wdata=0x27; done=1 in the same cycle.
REQ-034 Boundaries: all samples 0 -> byte 0x00; all samples -4096 -> byte 0xFF with no overflow; all samples +4095 -> byte 0x00.
REQ-035 Random 0-3 cycle in_valid gaps between samples, same stimulus as REQ-033 -> identical byte 0x27 and a single write.
REQ-036 MSG_BYTES=3, back-to-back samples -> writes at addresses 0,1,2 exactly 32 cycles apart; done with the third write; enable -> IDLE; enable again -> next frame restarts at address 0.
REQ-037 Reset after 10 samples of a frame -> no write_enable, IDLE; a restarted frame reproduces the REQ-033 result at address 0.
